stream_mux_rr: RTL and testbench

//   N-channel, W-bit registered stream multiplexer: the parametrised successor of the 2:1 select mux.

---
 rtl/stream_mux_rr.sv | 134 +++++++++++++
 tb/tb_stream_mux_rr.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux: external-select or round-robin grant, with
// the grant held on one channel from its first beat until its last beat.
module stream_mux_rr #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    parameter  int MODE  = 0,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] X,
    input  logic [N_CH-1:0]       X_VALID,
    input  logic [N_CH-1:0]       X_LAST,
    output logic [N_CH-1:0]       X_READY,
    input  logic [CH_W-1:0]       S,
    output logic [WIDTH-1:0]      Y,
    output logic                  Y_LAST,
    output logic [CH_W-1:0]       Y_CH,
    output logic                  Y_VALID,
    input  logic                  Y_READY
);

    typedef enum logic {UNLOCKED, LOCKED} lock_e;

    lock_e                       r_state, w_state_nxt;
    logic [CH_W-1:0]             r_lock_ch;
    logic [CH_W-1:0]             r_rr_ptr;
    logic [WIDTH-1:0]            r_y;
    logic                        r_y_last;
    logic [CH_W-1:0]             r_y_ch;
    logic                        r_y_valid;

    logic [N_CH-1:0][WIDTH-1:0]  w_x_arr;
    logic [CH_W-1:0]             w_rr_ch;
    logic                        w_rr_found;
    logic [CH_W-1:0]             w_cand;
    logic                        w_cand_ok;
    logic                        w_load_en;
    logic                        w_accept;
    logic                        w_last_c;

    assign w_x_arr   = X;
    assign w_load_en = !r_y_valid || Y_READY;

    // Round-robin search starts just after the last channel that finished a packet.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_ch    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % N_CH;
            if (!w_rr_found && X_VALID[idx]) begin
                w_rr_found = 1'b1;
                w_rr_ch    = CH_W'(idx);
            end
        end
    end

    always_comb begin
        w_cand    = '0;
        w_cand_ok = 1'b0;
        if (r_state == LOCKED) begin
            w_cand    = r_lock_ch;
            w_cand_ok = 1'b1;
        end else if (MODE == 0) begin
            w_cand    = S;
            w_cand_ok = int'(S) < N_CH;
        end else begin
            w_cand    = w_rr_ch;
            w_cand_ok = w_rr_found;
        end
    end

    // Ready is gated by rst_n so nothing is offered while the block is held in reset.
    for (genvar i = 0; i < N_CH; i++) begin : g_ready
        assign X_READY[i] = rst_n && w_load_en && w_cand_ok && X_VALID[i]
                            && (w_cand == CH_W'(i));
    end

    assign w_accept = |X_READY;
    assign w_last_c = X_LAST[w_cand];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            UNLOCKED: if (w_accept && !w_last_c) w_state_nxt = LOCKED;
            LOCKED:   if (w_accept &&  w_last_c) w_state_nxt = UNLOCKED;
            default:  w_state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= UNLOCKED;
            r_lock_ch <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == UNLOCKED && w_state_nxt == LOCKED)
                r_lock_ch <= w_cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= CH_W'(N_CH - 1);
        end else if (MODE == 1 && w_accept && w_last_c) begin
            r_rr_ptr <= w_cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_last  <= 1'b0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
        end else if (w_load_en) begin
            if (w_accept) begin
                r_y       <= w_x_arr[w_cand];
                r_y_last  <= w_last_c;
                r_y_ch    <= w_cand;
                r_y_valid <= 1'b1;
            end else begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign Y       = r_y;
    assign Y_LAST  = r_y_last;
    assign Y_CH    = r_y_ch;
    assign Y_VALID = r_y_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: one select-mode and one round-robin
// instance on shared stimulus, driven from a table plus a mid-packet reset.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] X;
    logic [3:0]  X_VALID, X_LAST;
    logic [1:0]  S;
    logic        Y_READY;

    logic [3:0]  m0_xr, m1_xr;
    logic [7:0]  m0_y, m1_y;
    logic        m0_yl, m1_yl, m0_yv, m1_yv;
    logic [1:0]  m0_ych, m1_ych;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .X(X), .X_VALID(X_VALID), .X_LAST(X_LAST),
        .X_READY(m0_xr), .S(S), .Y(m0_y), .Y_LAST(m0_yl), .Y_CH(m0_ych),
        .Y_VALID(m0_yv), .Y_READY(Y_READY)
    );

    stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .X(X), .X_VALID(X_VALID), .X_LAST(X_LAST),
        .X_READY(m1_xr), .S(S), .Y(m1_y), .Y_LAST(m1_yl), .Y_CH(m1_ych),
        .Y_VALID(m1_yv), .Y_READY(Y_READY)
    );

    typedef struct {
        bit          m1;
        logic [1:0]  s;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] x;
        logic        yr;
        logic [3:0]  xr;
        logic        yv;
        logic [7:0]  y;
        logic [1:0]  ych;
        logic        yl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit m1, logic [1:0] s, logic [3:0] v, logic [3:0] l,
                                logic [31:0] x, logic yr, logic [3:0] xr, logic yv,
                                logic [7:0] y, logic [1:0] ych, logic yl);
        vec_t t;
        t.m1 = m1; t.s = s; t.v = v; t.l = l; t.x = x; t.yr = yr;
        t.xr = xr; t.yv = yv; t.y = y; t.ych = ych; t.yl = yl;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        X = 32'h0; X_VALID = 4'b1111; X_LAST = 4'b0; S = 2'd0; Y_READY = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst m0 xready", 32'(m0_xr), 32'h0);
        chk("rst m1 xready", 32'(m1_xr), 32'h0);
        chk("rst m0 y",      {m0_yv, m0_yl, m0_ych, m0_y}, 32'h0);
        chk("rst m1 y",      {m1_yv, m1_yl, m1_ych, m1_y}, 32'h0);
        @(negedge clk);
        X_VALID = 4'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        // select mode: single beat, idle, S change mid-packet, stall, locked channel going idle
        tbl.push_back(mk(0, 2, 4'b0100, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 2, 1));
        tbl.push_back(mk(0, 2, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'hA5, 2, 1));
        tbl.push_back(mk(0, 1, 4'b0010, 4'b0000, 32'h00001100, 1, 4'b0010, 1, 8'h11, 1, 0));
        tbl.push_back(mk(0, 3, 4'b1010, 4'b0000, 32'h77002200, 1, 4'b0010, 1, 8'h22, 1, 0));
        tbl.push_back(mk(0, 3, 4'b1010, 4'b0010, 32'h77003300, 1, 4'b0010, 1, 8'h33, 1, 1));
        tbl.push_back(mk(0, 3, 4'b1000, 4'b1000, 32'h77000000, 1, 4'b1000, 1, 8'h77, 3, 1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 32'h0000005A, 0, 4'b0000, 1, 8'h77, 3, 1));
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 32'h0000005A, 1, 4'b0001, 1, 8'h5A, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 32'h000000C1, 1, 4'b0001, 1, 8'hC1, 0, 0));
        tbl.push_back(mk(0, 2, 4'b0100, 4'b0100, 32'h00EE0000, 1, 4'b0000, 0, 8'hC1, 0, 0));
        tbl.push_back(mk(0, 2, 4'b0100, 4'b0100, 32'h00EE0000, 1, 4'b0000, 0, 8'hC1, 0, 0));
        tbl.push_back(mk(0, 2, 4'b0101, 4'b0101, 32'h00EE00C2, 1, 4'b0001, 1, 8'hC2, 0, 1));
        tbl.push_back(mk(0, 2, 4'b0100, 4'b0100, 32'h00EE0000, 1, 4'b0100, 1, 8'hEE, 2, 1));
        // round-robin: rotation with wrap, idle, 4-beat locked packet vs ch1, then new packet
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 3, 4'b1111, 4'b1111, 32'h13121110, 1, 4'(1 << (k % 4)), 1,
                             8'(8'h10 + (k % 4)), 2'(k % 4), 1));
        tbl.push_back(mk(1, 3, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h10, 0, 1));
        tbl.push_back(mk(1, 3, 4'b1000, 4'b1000, 32'h13000000, 1, 4'b1000, 1, 8'h13, 3, 1));
        tbl.push_back(mk(1, 3, 4'b0011, 4'b0010, 32'h0000B1A0, 1, 4'b0001, 1, 8'hA0, 0, 0));
        tbl.push_back(mk(1, 1, 4'b0011, 4'b0010, 32'h0000B1A1, 1, 4'b0001, 1, 8'hA1, 0, 0));
        tbl.push_back(mk(1, 2, 4'b0011, 4'b0010, 32'h0000B1A2, 1, 4'b0001, 1, 8'hA2, 0, 0));
        tbl.push_back(mk(1, 3, 4'b0011, 4'b0011, 32'h0000B1A3, 1, 4'b0001, 1, 8'hA3, 0, 1));
        tbl.push_back(mk(1, 3, 4'b0010, 4'b0010, 32'h0000B100, 1, 4'b0010, 1, 8'hB1, 1, 1));
        tbl.push_back(mk(1, 3, 4'b0100, 4'b0000, 32'h00C00000, 1, 4'b0100, 1, 8'hC0, 2, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0 && tbl[i].m1 && !tbl[i-1].m1) do_reset();
            @(negedge clk);
            S = tbl[i].s; X_VALID = tbl[i].v; X_LAST = tbl[i].l; X = tbl[i].x;
            Y_READY = tbl[i].yr;
            #1;
            chk($sformatf("row%0d xready", i), 32'(tbl[i].m1 ? m1_xr : m0_xr), 32'(tbl[i].xr));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d yvalid", i), 32'(tbl[i].m1 ? m1_yv : m0_yv), 32'(tbl[i].yv));
            chk($sformatf("row%0d y", i),      32'(tbl[i].m1 ? m1_y  : m0_y),  32'(tbl[i].y));
            chk($sformatf("row%0d ych", i),    32'(tbl[i].m1 ? m1_ych : m0_ych), 32'(tbl[i].ych));
            chk($sformatf("row%0d ylast", i),  32'(tbl[i].m1 ? m1_yl : m0_yl), 32'(tbl[i].yl));
        end

        // Reset between clock edges while ch2 holds the lock and Y_VALID=1.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst yvalid", 32'(m1_yv), 32'h0);
        chk("midrst y",      32'(m1_y), 32'h0);
        chk("midrst ych",    32'(m1_ych), 32'h0);
        chk("midrst xready", 32'(m1_xr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        X_VALID = 4'b0101; X_LAST = 4'b0101; X = 32'h00C100D0; S = 2'd2; Y_READY = 1'b1;
        #1;
        chk("postrst xready", 32'(m1_xr), 32'h1);
        @(posedge clk);
        #1;
        chk("postrst y",      32'(m1_y), 32'hD0);
        chk("postrst ych",    32'(m1_ych), 32'h0);
        chk("postrst yvalid", 32'(m1_yv), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
